// File: rtl/match_event_pkg.sv
// rtl/match_event_pkg.sv - shared record type, run-length limit and FSM states for the match logger
package match_event_pkg;

  // Width of the timestamp field carried in each stored record
  localparam int EVT_TS_W = 32;

  // Longest run a single record can describe; longer runs are split
  localparam logic [7:0] RUN_LEN_MAX = 8'd255;

  typedef struct packed {
    logic [EVT_TS_W-1:0] timestamp;
    logic                mode;
    logic [7:0]          run_len;
  } match_evt_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/match_evt_fifo.sv
// rtl/match_evt_fifo.sv - synchronous event-record FIFO with flush and occupancy count
module match_evt_fifo
  import match_event_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  match_evt_t             i_push_data,
  input  logic                   i_pop,
  output match_evt_t             o_head_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  match_evt_t       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == (AW+1)'(DEPTH));
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is accepted then
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Record storage; contents are only observed while the FIFO is non-empty, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// rtl/match_event_logger.sv - turns pattern_match runs into timestamped records with saturating statistics
module match_event_logger
  import match_event_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = EVT_TS_W,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   pattern_match,
  input  logic                   mode_select,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [TS_W-1:0]        evt_timestamp,
  output logic                   evt_mode,
  output logic [7:0]             evt_run_len,
  output logic [CNT_W-1:0]       match_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fill_level
);

  run_state_t       r_state;
  run_state_t       w_state_nxt;
  logic [TS_W-1:0]  r_ts;
  logic [TS_W-1:0]  r_start_ts;
  logic             r_start_mode;
  logic [7:0]       r_len;
  logic [CNT_W-1:0] r_match_count;
  logic [CNT_W-1:0] r_drop_count;
  logic             r_overflow;
  logic             w_in;
  logic             w_push;
  logic             w_start;
  logic             w_len_inc;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  match_evt_t       w_rec;
  match_evt_t       w_head;

  assign w_in   = pattern_match & enable;
  assign w_pop  = ~w_empty & evt_ready;
  assign w_drop = w_push & w_full & ~w_pop;

  // Pack the run currently being closed into a FIFO record
  always_comb begin
    w_rec           = '0;
    w_rec.timestamp = EVT_TS_W'(r_start_ts);
    w_rec.mode      = r_start_mode;
    w_rec.run_len   = r_len;
  end

  // Free-running timestamp; only reset restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + 1'b1;
  end

  // Run FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Run FSM decisions: start, extend, close, or split a run at the length limit
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_start     = 1'b0;
    w_len_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_in) begin
          w_state_nxt = RUN;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        if (!w_in) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_len == RUN_LEN_MAX) begin
          w_push  = 1'b1;
          w_start = 1'b1;
        end else begin
          w_len_inc = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear) begin
      w_state_nxt = IDLE;
      w_push      = 1'b0;
      w_start     = 1'b0;
      w_len_inc   = 1'b0;
    end
  end

  // Context of the run in progress, captured at its first cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_ts   <= '0;
      r_start_mode <= 1'b0;
      r_len        <= '0;
    end else if (w_start) begin
      r_start_ts   <= r_ts;
      r_start_mode <= mode_select;
      r_len        <= 8'd1;
    end else if (w_len_inc) begin
      r_len <= r_len + 1'b1;
    end
  end

  // Saturating run/drop statistics and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_count <= '0;
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
    end else if (clear) begin
      r_match_count <= '0;
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push && r_match_count != '1) r_match_count <= r_match_count + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  match_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (clear),
    .i_push      (w_push),
    .i_push_data (w_rec),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fill_level)
  );

  assign evt_valid     = ~w_empty;
  assign evt_timestamp = w_empty ? '0 : TS_W'(w_head.timestamp);
  assign evt_mode      = w_empty ? 1'b0 : w_head.mode;
  assign evt_run_len   = w_empty ? 8'd0 : w_head.run_len;
  assign match_count   = r_match_count;
  assign drop_count    = r_drop_count;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_match_event_logger.sv
// tb/tb_match_event_logger.sv - directed self-checking bench for match_event_logger
module tb_match_event_logger;

  localparam int DEPTH = 8;
  localparam int TS_W  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic             pattern_match = 1'b0;
  logic             mode_select = 1'b0;
  logic             evt_ready = 1'b0;
  logic             evt_valid;
  logic [TS_W-1:0]  evt_timestamp;
  logic             evt_mode;
  logic [7:0]       evt_run_len;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;
  logic [3:0]       fill_level;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc;

  match_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .pattern_match(pattern_match), .mode_select(mode_select),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_timestamp(evt_timestamp),
    .evt_mode(evt_mode), .evt_run_len(evt_run_len), .match_count(match_count),
    .drop_count(drop_count), .overflow(overflow), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  // Bench time base: equals the value the timestamp should hold between edges
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single_run(output int unsigned t);
    t = cyc;
    pattern_match = 1'b1;
    tick();
    pattern_match = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", evt_valid); end
    checks++; if (evt_timestamp !== '0) begin failures++; $display("FAIL reset_ts got=%0d want=0", evt_timestamp); end
    checks++; if (evt_run_len !== 8'd0 || evt_mode !== 1'b0) begin failures++; $display("FAIL reset_rec got len=%0d mode=%0b want 0/0", evt_run_len, evt_mode); end
    checks++; if (match_count !== '0 || drop_count !== '0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", match_count, drop_count); end
    checks++; if (overflow !== 1'b0 || fill_level !== 4'd0) begin failures++; $display("FAIL reset_ovf_fill got=%0b/%0d want=0/0", overflow, fill_level); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    enable = 1'b1;
    evt_ready = 1'b1;
    mode_select = 1'b1;
    while (cyc < 10) tick();
    pattern_match = 1'b1;
    repeat (3) tick();
    pattern_match = 1'b0;
    mode_select = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b want=0", evt_valid); end
    tick();
    checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b want=1", evt_valid); end
    checks++; if (evt_timestamp !== 32'd10 || evt_mode !== 1'b1 || evt_run_len !== 8'd3) begin failures++; $display("FAIL basic_rec got ts=%0d mode=%0b len=%0d want 10/1/3", evt_timestamp, evt_mode, evt_run_len); end
    checks++; if (match_count !== 16'd1) begin failures++; $display("FAIL basic_match got=%0d want=1", match_count); end
    tick();
    checks++; if (evt_valid !== 1'b0 || fill_level !== 4'd0) begin failures++; $display("FAIL basic_popped got valid=%0b fill=%0d want 0/0", evt_valid, fill_level); end
    evt_ready = 1'b0;
  endtask

  task automatic test_long_run();
    int unsigned t;
    clear = 1'b1; tick(); clear = 1'b0;
    mode_select = 1'b1;
    t = cyc;
    pattern_match = 1'b1;
    tick();
    mode_select = 1'b0;
    repeat (299) tick();
    pattern_match = 1'b0;
    tick();
    checks++; if (fill_level !== 4'd2 || match_count !== 16'd2) begin failures++; $display("FAIL long_fill_match got=%0d/%0d want=2/2", fill_level, match_count); end
    checks++; if (evt_timestamp !== t || evt_mode !== 1'b1 || evt_run_len !== 8'd255) begin failures++; $display("FAIL long_rec0 got ts=%0d mode=%0b len=%0d want %0d/1/255", evt_timestamp, evt_mode, evt_run_len, t); end
    pop_one();
    checks++; if (evt_timestamp !== t + 255 || evt_mode !== 1'b0 || evt_run_len !== 8'd45) begin failures++; $display("FAIL long_rec1 got ts=%0d mode=%0b len=%0d want %0d/0/45", evt_timestamp, evt_mode, evt_run_len, t + 255); end
    pop_one();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL long_drained got=%0b want=0", evt_valid); end
  endtask

  task automatic test_overflow();
    int unsigned exp_ts [10];
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 10; i++) single_run(exp_ts[i]);
    checks++; if (fill_level !== 4'd8) begin failures++; $display("FAIL ovf_fill got=%0d want=8", fill_level); end
    checks++; if (drop_count !== 16'd2 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_drop got=%0d/%0b want=2/1", drop_count, overflow); end
    checks++; if (match_count !== 16'd10) begin failures++; $display("FAIL ovf_match got=%0d want=10", match_count); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_timestamp !== exp_ts[i] || evt_run_len !== 8'd1) begin failures++; $display("FAIL ovf_order%0d got v=%0b ts=%0d len=%0d want 1/%0d/1", i, evt_valid, evt_timestamp, evt_run_len, exp_ts[i]); end
      pop_one();
    end
    checks++; if (fill_level !== 4'd0 || evt_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got fill=%0d v=%0b want 0/0", fill_level, evt_valid); end
  endtask

  task automatic test_clear();
    int unsigned t;
    for (int i = 0; i < 3; i++) single_run(t);
    checks++; if (fill_level !== 4'd3 || match_count !== 16'd13) begin failures++; $display("FAIL clr_pre got fill=%0d match=%0d want 3/13", fill_level, match_count); end
    pattern_match = 1'b1;
    repeat (2) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (fill_level !== 4'd0 || evt_valid !== 1'b0) begin failures++; $display("FAIL clr_fifo got fill=%0d v=%0b want 0/0", fill_level, evt_valid); end
    checks++; if (match_count !== '0 || drop_count !== '0 || overflow !== 1'b0) begin failures++; $display("FAIL clr_stats got=%0d/%0d/%0b want 0/0/0", match_count, drop_count, overflow); end
    t = cyc;
    repeat (2) tick();
    pattern_match = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL clr_no_stale got=%0b want=0", evt_valid); end
    tick();
    checks++; if (evt_valid !== 1'b1 || evt_timestamp !== t || evt_run_len !== 8'd2) begin failures++; $display("FAIL clr_newrun got v=%0b ts=%0d len=%0d want 1/%0d/2", evt_valid, evt_timestamp, evt_run_len, t); end
    checks++; if (fill_level !== 4'd1 || match_count !== 16'd1) begin failures++; $display("FAIL clr_newcnt got=%0d/%0d want=1/1", fill_level, match_count); end
    pop_one();
  endtask

  task automatic test_full_push_pop();
    int unsigned ts8 [8];
    int unsigned t9;
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 8; i++) single_run(ts8[i]);
    checks++; if (fill_level !== 4'd8) begin failures++; $display("FAIL full_fill got=%0d want=8", fill_level); end
    t9 = cyc;
    pattern_match = 1'b1;
    tick();
    pattern_match = 1'b0;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++; if (fill_level !== 4'd8 || drop_count !== '0 || overflow !== 1'b0) begin failures++; $display("FAIL full_pp got fill=%0d drop=%0d ovf=%0b want 8/0/0", fill_level, drop_count, overflow); end
    checks++; if (match_count !== 16'd9 || evt_timestamp !== ts8[1]) begin failures++; $display("FAIL full_pp_head got match=%0d ts=%0d want 9/%0d", match_count, evt_timestamp, ts8[1]); end
    repeat (7) pop_one();
    checks++; if (evt_timestamp !== t9 || evt_run_len !== 8'd1 || fill_level !== 4'd1) begin failures++; $display("FAIL full_last got ts=%0d len=%0d fill=%0d want %0d/1/1", evt_timestamp, evt_run_len, fill_level, t9); end
    pop_one();
  endtask

  task automatic test_enable();
    clear = 1'b1; tick(); clear = 1'b0;
    pattern_match = 1'b1;
    repeat (2) tick();
    enable = 1'b0;
    tick();
    repeat (3) tick();
    checks++; if (fill_level !== 4'd1 || evt_run_len !== 8'd2) begin failures++; $display("FAIL enable_end got fill=%0d len=%0d want 1/2", fill_level, evt_run_len); end
    pattern_match = 1'b0;
    enable = 1'b1;
    pop_one();
  endtask

  task automatic test_async_reset();
    int unsigned t;
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 2; i++) single_run(t);
    pattern_match = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (evt_valid !== 1'b0 || fill_level !== 4'd0) begin failures++; $display("FAIL arst_fifo got v=%0b fill=%0d want 0/0", evt_valid, fill_level); end
    checks++; if (evt_timestamp !== '0 || evt_run_len !== 8'd0 || match_count !== '0 || drop_count !== '0 || overflow !== 1'b0) begin failures++; $display("FAIL arst_outs got ts=%0d len=%0d m=%0d d=%0d o=%0b want all 0", evt_timestamp, evt_run_len, match_count, drop_count, overflow); end
    pattern_match = 1'b0;
    tick();
    rst = 1'b0;
    pattern_match = 1'b1;
    tick();
    pattern_match = 1'b0;
    tick();
    checks++; if (evt_valid !== 1'b1 || evt_timestamp !== 32'd0 || evt_run_len !== 8'd1) begin failures++; $display("FAIL arst_restart got v=%0b ts=%0d len=%0d want 1/0/1", evt_valid, evt_timestamp, evt_run_len); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_run();
    test_overflow();
    test_clear();
    test_full_push_pop();
    test_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the pattern detector's `pattern_match` output. It converts match runs into timestamped event records: each run is a maximal group of consecutive cycles with `pattern_match` high. Records are buffered in a small FIFO and offered to the scoreboard/host side through a valid/ready handshake. The block also keeps saturating match and drop statistics.

## Interface
Parameters:
- `DEPTH`, 8, event FIFO depth; power of two, ≥2
- `TS_W`, 32, timestamp width
- `CNT_W`, 16, statistics counter width

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  run detection enabled; low is treated as `pattern_match`=0
- `clear`  in  1  synchronous flush of FIFO, counters, sticky flag and run state
- `pattern_match`  in  1  match output of the pattern detector
- `mode_select`  in  1  detector mode, captured at run start
- `evt_valid`  out  1  FIFO head record available
- `evt_ready`  in  1  consumer accepts head record
- `evt_timestamp`  out  TS_W  timestamp of the run's first cycle
- `evt_mode`  out  1  `mode_select` at the run's first cycle
- `evt_run_len`  out  8  run length in cycles, 1..255
- `match_count`  out  CNT_W  runs completed (pushed or dropped), saturating
- `drop_count`  out  CNT_W  runs lost to a full FIFO, saturating
- `overflow`  out  1  sticky; set on the first drop
- `fill_level`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Free-running timestamp `ts` counts from 0 after reset and increments every cycle. It wraps modulo 2^TS_W. `clear` does not affect it.
- The run FSM has two states:
  - IDLE → RUN when the sampled `pattern_match & enable` is 1. In that cycle it latches `start_ts`=`ts`, `start_mode`=`mode_select` and `len`=1.
  - RUN, input still 1 and `len`<255: `len`++.
  - RUN, input 0: push {`start_ts`, `start_mode`, `len`} and go to IDLE.
  - RUN, input 1 and `len`==255: push with `len`=255, stay in RUN, and start a new run in that same cycle (`start_ts`=`ts`, `len`=1).
- Push handling:
  - FIFO not full, or a pop happens in the same cycle: the record is stored.
  - Otherwise the record is dropped: `drop_count`++ (saturating) and `overflow`=1.
  - `match_count`++ (saturating) on every completed run, whether stored or dropped.
- Pop occurs when `evt_valid & evt_ready`. The `evt_*` outputs show the FIFO head and are held stable while `evt_valid` is high and `evt_ready` is low.
- `clear` has priority over all other activity in its cycle:
  - empties the FIFO and zeroes both counters and `overflow`
  - forces IDLE and discards any run in progress, with no push
  - does not raise `evt_valid` in the following cycle
- `enable` falling during a run ends the run normally (push).

## Timing
- Reset values: `evt_valid`=0, `evt_timestamp`=0, `evt_mode`=0, `evt_run_len`=0, `match_count`=0, `drop_count`=0, `overflow`=0, `fill_level`=0. Internally `ts`=0 and the FSM is in IDLE.
- Reset mid-run discards the run and all buffered records immediately.
- Latency: the cycle that samples the run end pushes. `evt_valid` and `fill_level` update at the next posedge, i.e. one cycle after the falling edge is sampled.
- `fill_level` updates on push/pop:
  - simultaneous push and pop: unchanged
  - simultaneous push and pop while full: unchanged, no drop
  - pop on empty: ignored
- Counters stick at 2^CNT_W−1.
- `ts` wrap is not flagged; consumers handle the modulo.

## Structure
- Package `match_event_pkg`:
  - typedef `match_evt_t` holding {timestamp, mode, run_len}
  - constant `RUN_LEN_MAX`=255
  - FSM state enum {IDLE, RUN}
- Sub-module `match_evt_fifo`: synchronous FIFO of `match_evt_t`, parameter `DEPTH`.
  - ports: push/pop, full/empty, count
  - reset: asynchronous, active-high
  - flush: synchronous
- Top level contains the timestamp counter, run FSM, statistics counters and handshake glue.

## Test plan
- Reset, then hold `pattern_match` high at ts 10..12 with `mode_select`=1; `evt_ready`=1 → one record {ts=10, mode=1, len=3}, with `evt_valid` high at ts=14; `match_count`=1.
- `pattern_match` held high for 300 cycles starting at ts=T → records {T, len 255} and {T+255, len 45}; `match_count`=2.
- `evt_ready`=0, then 10 single-cycle runs with DEPTH=8 → `fill_level`=8, `drop_count`=2, `overflow`=1, `match_count`=10. After draining, the first 8 timestamps appear in order.
- FIFO full with `evt_ready`=1 and a run ending in the same cycle → record accepted, `fill_level` stays 8, `drop_count` unchanged.
- `clear` pulsed mid-run with 3 records buffered → `fill_level`=0, counters 0, `overflow`=0, no record for the interrupted run. A new run starting 1 cycle later logs normally.
- `rst` asserted asynchronously mid-run with records buffered → all outputs zero without waiting for a clock edge. After release, `ts` restarts at 0.
